// File: rtl/ifetch_prefetch_pkg.sv
// Shared definitions for the instruction fetch / prefetch block.
//   - Fetch FSM state type and encodings (idle, wait for response, drain stale response)
//   - ENABLE / DISABLE single-bit constants
//   - Default address and instruction widths
package ifetch_prefetch_pkg;

    localparam int unsigned ADDRESS_WIDTH     = 32;
    localparam int unsigned INSTRUCTION_WIDTH = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t StIdle  = 2'd0;  // no request outstanding
    localparam fetch_state_t StWait  = 2'd1;  // request accepted, response pending
    localparam fetch_state_t StDrain = 2'd2;  // next response belongs to a squashed fetch

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous circular buffer of DEPTH entries (DEPTH a power of two, >= 2).
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset, empties the buffer
//   flush_i   empties the buffer; wins over push and pop
//   push_i    write wdata_i at tail (ignored when full)
//   wdata_i   entry to write
//   pop_i     advance head (ignored when empty)
//   rdata_o   entry at head (combinational)
//   count_o   number of stored entries
//   full_o    count_o == DEPTH
//   empty_o   count_o == 0
module ifetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PtrW'(1);
            if (do_pop)  head_d = head_q + PtrW'(1);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch unit with a DEPTH-entry prefetch buffer.
// Issues one sequential fetch at a time, buffers returned {inst, pc} pairs and drains
// them to the instruction queue one per cycle. A ROB redirect flushes the buffer and
// squashes any fetch still in flight.
// Ports:
//   clk_in / rst_in        clock (rising edge) / synchronous active-high reset
//   rdy_in                 global enable; low freezes all state
//   mem_req_rdy_in         memory can accept a request
//   mem_req_en_out/pc_out  fetch request valid / address (combinational)
//   mem_resp_en_in/inst_in response pulse / returned instruction
//   iq_rdy_in              instruction queue can accept
//   iq_inst_en_out         registered one-cycle delivery pulse
//   iq_inst_out/iq_pc_out  delivered instruction / PC (registered, hold between pulses)
//   rob_en_in / rob_pc_in  redirect request / target
//   busy_out               fetch outstanding or buffer non-empty
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDRESS_WIDTH,
    parameter int unsigned        INST_W   = INSTRUCTION_WIDTH,
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        PC_STEP  = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              mem_req_rdy_in,
    output logic              mem_req_en_out,
    output logic [ADDR_W-1:0] mem_req_pc_out,
    input  logic              mem_resp_en_in,
    input  logic [INST_W-1:0] mem_resp_inst_in,
    input  logic              iq_rdy_in,
    output logic              iq_inst_en_out,
    output logic [INST_W-1:0] iq_inst_out,
    output logic [ADDR_W-1:0] iq_pc_out,
    input  logic              rob_en_in,
    input  logic [ADDR_W-1:0] rob_pc_in,
    output logic              busy_out
);

    localparam int unsigned EntW = INST_W + ADDR_W;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              iq_en_q;
    logic [INST_W-1:0] iq_inst_q;
    logic [ADDR_W-1:0] iq_pc_q;

    logic                   buf_push, buf_pop, buf_flush;
    logic                   buf_full, buf_empty;
    logic [EntW-1:0]        buf_rdata;
    logic [$clog2(DEPTH):0] buf_count;
    logic                   req_fire;

    assign mem_req_en_out = rdy_in & (state_q == StIdle) & ~buf_full & ~rob_en_in;
    assign mem_req_pc_out = fetch_pc_q;
    assign req_fire       = mem_req_en_out & mem_req_rdy_in;

    // Space is guaranteed on push: a request is only issued while the buffer is not full.
    assign buf_push  = rdy_in & ~rob_en_in & (state_q == StWait) & mem_resp_en_in;
    assign buf_pop   = rdy_in & ~rob_en_in & iq_rdy_in & ~buf_empty;
    assign buf_flush = rdy_in & rob_en_in;

    ifetch_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .flush_i (buf_flush),
        .push_i  (buf_push),
        .wdata_i ({mem_resp_inst_in, req_pc_q}),
        .pop_i   (buf_pop),
        .rdata_o (buf_rdata),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (rdy_in == ENABLE) begin
            if (rob_en_in) begin
                fetch_pc_d = rob_pc_in;
                // A response arriving with the redirect is dropped and ends the fetch.
                // In DRAIN the awaited stale response is consumed even under a redirect,
                // otherwise the FSM would wait for a response that never comes.
                if (state_q == StWait) begin
                    state_d = mem_resp_en_in ? StIdle : StDrain;
                end else if (state_q == StDrain && mem_resp_en_in) begin
                    state_d = StIdle;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (req_fire) begin
                            req_pc_d = fetch_pc_q;
                            state_d  = StWait;
                        end
                    end
                    StWait: begin
                        if (mem_resp_en_in) begin
                            fetch_pc_d = req_pc_q + ADDR_W'(PC_STEP);
                            state_d    = StIdle;
                        end
                    end
                    StDrain: begin
                        if (mem_resp_en_in) state_d = StIdle;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            iq_en_q    <= DISABLE;
            iq_inst_q  <= '0;
            iq_pc_q    <= '0;
        end else begin
            // buf_pop already includes rdy_in, so the pulse drops while frozen.
            iq_en_q <= buf_pop;
            if (buf_pop) begin
                iq_inst_q <= buf_rdata[EntW-1:ADDR_W];
                iq_pc_q   <= buf_rdata[ADDR_W-1:0];
            end
            if (rdy_in == ENABLE) begin
                state_q    <= state_d;
                fetch_pc_q <= fetch_pc_d;
                req_pc_q   <= req_pc_d;
            end
        end
    end

    assign iq_inst_en_out = iq_en_q;
    assign iq_inst_out    = iq_inst_q;
    assign iq_pc_out      = iq_pc_q;
    assign busy_out       = (state_q != StIdle) | (buf_count != '0);

`ifndef SYNTHESIS
    // A response with nothing outstanding points at a broken memory handshake.
    spurious_resp_a: assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && mem_resp_en_in && state_q == StIdle));
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: directed scenarios plus a randomized run, all checked against
// a transaction-level model (fetch epochs, expected delivery queue, sequential PC rule).
module tb_ifetch_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1, rdy_in = 1'b0, mem_req_rdy_in = 1'b0;
    logic        mem_resp_en_in = 1'b0, iq_rdy_in = 1'b0, rob_en_in = 1'b0;
    logic [31:0] mem_resp_inst_in = '0, rob_pc_in = '0;
    logic        mem_req_en_out, iq_inst_en_out, busy_out;
    logic [31:0] mem_req_pc_out, iq_inst_out, iq_pc_out;

    logic        b_rst = 1'b1, b_rdy = 1'b0, b_mreq_rdy = 1'b0, b_resp_en = 1'b0;
    logic        b_iq_rdy = 1'b0, b_rob_en = 1'b0;
    logic [31:0] b_resp_inst = '0, b_rob_pc = '0;
    logic        b_req_en, b_iq_en, b_busy;
    logic [31:0] b_req_pc, b_iq_inst, b_iq_pc;

    always #5 clk = ~clk;

    ifetch_prefetch #(.DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_req_rdy_in(mem_req_rdy_in),
        .mem_req_en_out(mem_req_en_out), .mem_req_pc_out(mem_req_pc_out),
        .mem_resp_en_in(mem_resp_en_in), .mem_resp_inst_in(mem_resp_inst_in),
        .iq_rdy_in(iq_rdy_in), .iq_inst_en_out(iq_inst_en_out), .iq_inst_out(iq_inst_out),
        .iq_pc_out(iq_pc_out), .rob_en_in(rob_en_in), .rob_pc_in(rob_pc_in),
        .busy_out(busy_out)
    );

    ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_in(clk), .rst_in(b_rst), .rdy_in(b_rdy), .mem_req_rdy_in(b_mreq_rdy),
        .mem_req_en_out(b_req_en), .mem_req_pc_out(b_req_pc),
        .mem_resp_en_in(b_resp_en), .mem_resp_inst_in(b_resp_inst),
        .iq_rdy_in(b_iq_rdy), .iq_inst_en_out(b_iq_en), .iq_inst_out(b_iq_inst),
        .iq_pc_out(b_iq_pc), .rob_en_in(b_rob_en), .rob_pc_in(b_rob_pc),
        .busy_out(b_busy)
    );

    int n_checks = 0, n_fail = 0;
    int cyc = 0, lat = 1;
    int req_en_bad = 0, busy_bad = 0, freeze_bad = 0;

    // Memory / reference model state
    logic        pend_v = 1'b0;
    int          pend_cnt = 0, pend_ep = 0, epoch = 0;
    logic [31:0] pend_pc = '0, exp_req_pc = '0;
    logic [63:0] buf_q[$];      // entries the model believes are buffered, oldest first
    logic [63:0] obs_q[$], exp_q[$];
    logic [31:0] req_obs[$], req_exp[$];
    int          pulse_cyc[$], resp_cyc[$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // One clock cycle: memory responder, pre-edge observation, model update after the edge.
    task automatic step();
        logic        rst_s, rdy_s, rob_s, acc_s, resp_s, exp_en;
        logic [31:0] rob_pc_s, req_pc_s, old_inst, old_pc;
        mem_resp_en_in = 1'b0;
        if (rdy_in && !rst_in && pend_v) begin
            if (pend_cnt > 0) pend_cnt--;
            if (pend_cnt == 0) begin
                mem_resp_en_in   = 1'b1;
                mem_resp_inst_in = inst_of(pend_pc);
            end
        end
        #1;
        rst_s = rst_in; rdy_s = rdy_in; rob_s = rob_en_in; rob_pc_s = rob_pc_in;
        acc_s = mem_req_en_out && mem_req_rdy_in;
        resp_s = mem_resp_en_in;
        req_pc_s = mem_req_pc_out;
        old_inst = iq_inst_out; old_pc = iq_pc_out;
        if (!rst_s) begin
            exp_en = rdy_s && !pend_v && (buf_q.size() < DEPTH) && !rob_s;
            if (mem_req_en_out !== exp_en) req_en_bad++;
            if (busy_out !== (pend_v || buf_q.size() != 0)) busy_bad++;
        end
        if (resp_s) resp_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            pend_v = 1'b0;
            buf_q.delete();
            exp_req_pc = '0;
            return;
        end
        if (!rdy_s) begin
            if (iq_inst_en_out !== 1'b0 || iq_inst_out !== old_inst || iq_pc_out !== old_pc)
                freeze_bad++;
            return;
        end
        if (resp_s) begin
            if (!rob_s && pend_ep == epoch) begin
                buf_q.push_back({inst_of(pend_pc), pend_pc});
                exp_req_pc = pend_pc + 32'd4;
            end
            pend_v = 1'b0;
        end
        if (rob_s) begin
            buf_q.delete();
            epoch++;
            exp_req_pc = rob_pc_s;
        end
        if (acc_s) begin
            req_obs.push_back(req_pc_s);
            req_exp.push_back(exp_req_pc);
            pend_v = 1'b1; pend_cnt = lat; pend_pc = req_pc_s; pend_ep = epoch;
        end
        if (iq_inst_en_out === 1'b1) begin
            obs_q.push_back({iq_inst_out, iq_pc_out});
            pulse_cyc.push_back(cyc);
            if (buf_q.size() > 0) exp_q.push_back(buf_q.pop_front());
            else exp_q.push_back('x);
        end
    endtask

    task automatic apply_reset();
        rdy_in = 1'b1; mem_req_rdy_in = 1'b0; iq_rdy_in = 1'b0; rob_en_in = 1'b0;
        rob_pc_in = '0; rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        obs_q.delete(); exp_q.delete(); req_obs.delete(); req_exp.delete();
        pulse_cyc.delete(); resp_cyc.delete();
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b0; mem_req_rdy_in = 1'b0;
        step();
        rst_in = 1'b0; rdy_in = 1'b1;
        #1;
        n_checks++; if (iq_inst_en_out !== 1'b0) begin n_fail++;
            $display("FAIL reset_iq_en: got %b want 0", iq_inst_en_out); end
        n_checks++; if (iq_inst_out !== 32'h0 || iq_pc_out !== 32'h0) begin n_fail++;
            $display("FAIL reset_iq_data: got %h/%h want 0/0", iq_inst_out, iq_pc_out); end
        n_checks++; if (busy_out !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy_out); end
        n_checks++; if (mem_req_en_out !== 1'b1 || mem_req_pc_out !== 32'h0) begin n_fail++;
            $display("FAIL reset_req: got en=%b pc=%h want en=1 pc=0",
                     mem_req_en_out, mem_req_pc_out); end
    endtask

    task automatic test_sequential();
        apply_reset();
        lat = 1; mem_req_rdy_in = 1'b1; iq_rdy_in = 1'b1;
        for (int i = 0; i < 60 && obs_q.size() < 4; i++) step();
        mem_req_rdy_in = 1'b0;
        n_checks++; if (obs_q.size() < 4) begin n_fail++;
            $display("FAIL seq_count: got %0d deliveries want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            logic [31:0] pc;
            pc = 32'(i * 4);
            n_checks++; if (obs_q[i] !== {inst_of(pc), pc}) begin n_fail++;
                $display("FAIL seq_data[%0d]: got %h want %h", i, obs_q[i], {inst_of(pc), pc}); end
            n_checks++; if (req_obs[i] !== pc) begin n_fail++;
                $display("FAIL seq_req_pc[%0d]: got %h want %h", i, req_obs[i], pc); end
        end
        if (obs_q.size() >= 4 && resp_cyc.size() > 0) begin
            n_checks++; if (pulse_cyc[0] - resp_cyc[0] != 2) begin n_fail++;
                $display("FAIL seq_latency: got %0d want 2", pulse_cyc[0] - resp_cyc[0]); end
            for (int i = 1; i < 4; i++) begin
                n_checks++; if (pulse_cyc[i] - pulse_cyc[i-1] != 2) begin n_fail++;
                    $display("FAIL seq_spacing[%0d]: got %0d want 2", i,
                             pulse_cyc[i] - pulse_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_full();
        apply_reset();
        lat = 1; mem_req_rdy_in = 1'b1; iq_rdy_in = 1'b0;
        repeat (20) step();
        n_checks++; if (req_obs.size() != 4) begin n_fail++;
            $display("FAIL full_req_count: got %0d want 4", req_obs.size()); end
        n_checks++; if (mem_req_en_out !== 1'b0) begin n_fail++;
            $display("FAIL full_req_en: got %b want 0", mem_req_en_out); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++;
            $display("FAIL full_no_delivery: got %0d want 0", obs_q.size()); end
        iq_rdy_in = 1'b1;
        for (int i = 0; i < 40 && (obs_q.size() < 4 || req_obs.size() < 5); i++) step();
        mem_req_rdy_in = 1'b0;
        n_checks++; if (obs_q.size() < 4 || req_obs.size() < 5) begin n_fail++;
            $display("FAIL full_resume: got %0d deliveries %0d requests want 4/5",
                     obs_q.size(), req_obs.size()); end
        else begin
            n_checks++; if (pulse_cyc[3] - pulse_cyc[0] != 3) begin n_fail++;
                $display("FAIL full_burst: got span %0d want 3", pulse_cyc[3] - pulse_cyc[0]); end
            n_checks++; if (obs_q[3][31:0] !== 32'hc) begin n_fail++;
                $display("FAIL full_last_pc: got %h want c", obs_q[3][31:0]); end
            n_checks++; if (req_obs[4] !== 32'h10) begin n_fail++;
                $display("FAIL full_next_pc: got %h want 10", req_obs[4]); end
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        lat = 4; mem_req_rdy_in = 1'b1; iq_rdy_in = 1'b1;
        step();
        mem_req_rdy_in = 1'b0; rob_en_in = 1'b1; rob_pc_in = 32'h100;
        step();
        rob_en_in = 1'b0;
        #1;
        n_checks++; if (mem_req_en_out !== 1'b0 || busy_out !== 1'b1) begin n_fail++;
            $display("FAIL rdw_drain: got en=%b busy=%b want 0/1", mem_req_en_out, busy_out); end
        lat = 1; mem_req_rdy_in = 1'b1;
        for (int i = 0; i < 40 && obs_q.size() < 1; i++) step();
        mem_req_rdy_in = 1'b0;
        n_checks++; if (obs_q.size() < 1 || req_obs.size() < 2) begin n_fail++;
            $display("FAIL rdw_progress: got %0d deliveries want 1", obs_q.size()); end
        else begin
            n_checks++; if (req_obs[1] !== 32'h100) begin n_fail++;
                $display("FAIL rdw_req_pc: got %h want 100", req_obs[1]); end
            n_checks++; if (obs_q[0] !== {inst_of(32'h100), 32'h100}) begin n_fail++;
                $display("FAIL rdw_first: got %h want %h", obs_q[0], {inst_of(32'h100), 32'h100}); end
        end
    endtask

    task automatic test_redirect_resp();
        apply_reset();
        lat = 1; mem_req_rdy_in = 1'b1; iq_rdy_in = 1'b1;
        step();
        mem_req_rdy_in = 1'b0; rob_en_in = 1'b1; rob_pc_in = 32'h200;
        step();
        rob_en_in = 1'b0;
        #1;
        n_checks++; if (resp_cyc.size() != 1) begin n_fail++;
            $display("FAIL rdr_setup: got %0d responses want 1", resp_cyc.size()); end
        n_checks++; if (mem_req_en_out !== 1'b1 || mem_req_pc_out !== 32'h200) begin n_fail++;
            $display("FAIL rdr_req: got en=%b pc=%h want 1/200", mem_req_en_out, mem_req_pc_out); end
        n_checks++; if (busy_out !== 1'b0) begin n_fail++;
            $display("FAIL rdr_busy: got %b want 0", busy_out); end
        mem_req_rdy_in = 1'b1;
        for (int i = 0; i < 20 && obs_q.size() < 1; i++) step();
        mem_req_rdy_in = 1'b0;
        n_checks++; if (obs_q.size() < 1 || obs_q[0][31:0] !== 32'h200) begin n_fail++;
            $display("FAIL rdr_first: got %0d deliveries, first pc %h want 200", obs_q.size(),
                     obs_q.size() > 0 ? obs_q[0][31:0] : 32'hx); end
    endtask

    task automatic test_rdy_freeze();
        apply_reset();
        lat = 6; mem_req_rdy_in = 1'b1; iq_rdy_in = 1'b1;
        for (int i = 0; i < 30 && obs_q.size() < 1; i++) step();
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (iq_inst_en_out !== 1'b0 || mem_req_en_out !== 1'b0 || mem_req_pc_out !== 32'h4 ||
                iq_pc_out !== 32'h0 || iq_inst_out !== inst_of(32'h0) || busy_out !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got iq_en=%b req_en=%b req_pc=%h iq_pc=%h busy=%b want 0/0/4/0/1",
                         i, iq_inst_en_out, mem_req_en_out, mem_req_pc_out, iq_pc_out, busy_out);
            end
        end
        rdy_in = 1'b1;
        for (int i = 0; i < 40 && obs_q.size() < 2; i++) step();
        mem_req_rdy_in = 1'b0;
        n_checks++; if (obs_q.size() < 2) begin n_fail++;
            $display("FAIL freeze_resume: got %0d deliveries want 2", obs_q.size()); end
        else begin
            n_checks++; if (obs_q[1] !== {inst_of(32'h4), 32'h4}) begin n_fail++;
                $display("FAIL freeze_data: got %h want %h", obs_q[1], {inst_of(32'h4), 32'h4}); end
            n_checks++; if (pulse_cyc[1] - pulse_cyc[0] != 12) begin n_fail++;
                $display("FAIL freeze_timing: got %0d want 12", pulse_cyc[1] - pulse_cyc[0]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        lat = 20; mem_req_rdy_in = 1'b1;
        step();
        mem_req_rdy_in = 1'b0;
        step(); step();
        rst_in = 1'b1; rdy_in = 1'b0;
        step();
        rst_in = 1'b0; rdy_in = 1'b1;
        #1;
        n_checks++;
        if (busy_out !== 1'b0 || mem_req_en_out !== 1'b1 || mem_req_pc_out !== 32'h0 ||
            iq_inst_en_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_wait: got busy=%b en=%b pc=%h iq_en=%b want 0/1/0/0",
                     busy_out, mem_req_en_out, mem_req_pc_out, iq_inst_en_out);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] winst;
        winst = 32'hdead_beef;
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0; b_rdy = 1'b1; b_mreq_rdy = 1'b1;
        #1;
        n_checks++; if (b_req_en !== 1'b1 || b_req_pc !== 32'hFFFF_FFFC) begin n_fail++;
            $display("FAIL wrap_first: got en=%b pc=%h want 1/fffffffc", b_req_en, b_req_pc); end
        @(posedge clk); #1;
        b_mreq_rdy = 1'b0; b_resp_en = 1'b1; b_resp_inst = winst;
        @(posedge clk); #1;
        b_resp_en = 1'b0; b_mreq_rdy = 1'b1; b_iq_rdy = 1'b1;
        #1;
        n_checks++; if (b_req_en !== 1'b1 || b_req_pc !== 32'h0) begin n_fail++;
            $display("FAIL wrap_second: got en=%b pc=%h want 1/0", b_req_en, b_req_pc); end
        @(posedge clk); #1;
        b_mreq_rdy = 1'b0;
        n_checks++; if (b_iq_en !== 1'b1 || b_iq_pc !== 32'hFFFF_FFFC || b_iq_inst !== winst) begin
            n_fail++;
            $display("FAIL wrap_deliver: got en=%b pc=%h inst=%h want 1/fffffffc/%h",
                     b_iq_en, b_iq_pc, b_iq_inst, winst); end
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        #1;
        n_checks++;
        if (b_busy !== 1'b0 || b_req_pc !== 32'hFFFF_FFFC || b_iq_en !== 1'b0 || b_iq_pc !== 32'h0)
        begin
            n_fail++;
            $display("FAIL wrap_reset: got busy=%b pc=%h iq_en=%b iq_pc=%h want 0/fffffffc/0/0",
                     b_busy, b_req_pc, b_iq_en, b_iq_pc);
        end
    endtask

    task automatic test_random();
        int mism;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            mem_req_rdy_in = ($urandom_range(0, 9) < 7);
            iq_rdy_in      = ($urandom_range(0, 9) < 6);
            rdy_in         = ($urandom_range(0, 9) < 9);
            rob_en_in      = ($urandom_range(0, 99) < 4);
            rob_pc_in      = $urandom() & 32'hFFFF_FFFC;
            lat            = $urandom_range(1, 5);
            step();
        end
        rdy_in = 1'b1; rob_en_in = 1'b0; mem_req_rdy_in = 1'b0; iq_rdy_in = 1'b1;
        for (int i = 0; i < 60 && (pend_v || buf_q.size() != 0); i++) step();
        step();
        n_checks++; if (pend_v || buf_q.size() != 0) begin n_fail++;
            $display("FAIL rand_quiesce: got pend=%b buffered=%0d want 0/0", pend_v, buf_q.size()); end
        n_checks++; if (obs_q.size() < 50) begin n_fail++;
            $display("FAIL rand_activity: got %0d deliveries want >= 50", obs_q.size()); end
        mism = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; mism++;
                if (mism < 5) $display("FAIL rand_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 0; i < req_obs.size(); i++) begin
            n_checks++; if (req_obs[i] !== req_exp[i]) begin n_fail++; mism++;
                if (mism < 10) $display("FAIL rand_req_pc[%0d]: got %h want %h", i, req_obs[i], req_exp[i]); end
        end
        n_checks++; if (req_en_bad != 0) begin n_fail++;
            $display("FAIL req_en_rule: got %0d bad cycles want 0", req_en_bad); end
        n_checks++; if (busy_bad != 0) begin n_fail++;
            $display("FAIL busy_rule: got %0d bad cycles want 0", busy_bad); end
        n_checks++; if (freeze_bad != 0) begin n_fail++;
            $display("FAIL freeze_rule: got %0d bad cycles want 0", freeze_bad); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_redirect_wait();
        test_redirect_resp();
        test_rdy_freeze();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
